// File: rtl/ebi_pkg.sv
// Shared definitions for the EBI initiator: phase states, counter width,
// rd_wr encoding and the values the bus pins take while no cycle is running.
package ebi_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_TURN
   } ebi_state_e;

   localparam logic RD = 1'b1;
   localparam logic WR = 1'b0;

   localparam logic       IDLE_CS_N    = 1'b1;
   localparam logic       IDLE_OE_N    = 1'b1;
   localparam logic [3:0] IDLE_WE_N    = 4'hF;
   localparam logic       IDLE_RD_WR   = RD;
   localparam logic       IDLE_DATA_OE = 1'b0;

endpackage

// File: rtl/ebi_wait_cnt.sv
// Loadable down-counter timing one bus phase; done is high once the count
// has reached zero, so a load value of N-1 gives a phase of N cycles.
module ebi_wait_cnt
   import ebi_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/ebi_master.sv
// EBI bus initiator: turns a single-word valid/ready request into a
// cs_n/oe_n/we_n bus cycle with programmable setup, strobe, hold and turnaround.
module ebi_master
   import ebi_pkg::*;
#(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 3,
   parameter int HOLD_CYC   = 1,
   parameter int TURN_CYC   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [23:0] req_addr,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        cs_n,
   output logic        oe_n,
   output logic [3:0]  we_n,
   output logic        rd_wr,
   output logic [23:0] ebi_addr,
   output logic [31:0] ebi_data_o,
   output logic        ebi_data_oe,
   input  logic [31:0] ebi_data_i
);

   if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
      $error("SETUP_CYC must be in 1..15");
   end
   if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
      $error("STROBE_CYC must be in 1..15");
   end
   if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
      $error("HOLD_CYC must be in 1..15");
   end
   if (TURN_CYC < 0 || TURN_CYC > 15) begin : g_bad_turn
      $error("TURN_CYC must be in 0..15");
   end

   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] TURN_LD   = (TURN_CYC > 0) ? CNT_W'(TURN_CYC - 1) : '0;
   localparam bit               HAS_TURN  = (TURN_CYC > 0);

   ebi_state_e       state, state_nxt;
   logic             wr_q;
   logic [3:0]       be_q;
   logic             accept;
   logic             capture;
   logic             ack_nxt;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_done;

   logic             wr_sel;
   logic [3:0]       be_sel;
   logic             active_nxt;
   logic             strobe_nxt;

   ebi_wait_cnt u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .done     (cnt_done)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      ack_nxt   = 1'b0;
      cnt_load  = 1'b0;
      cnt_val   = '0;
      unique case (state)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               accept    = 1'b1;
               state_nxt = ST_SETUP;
               cnt_load  = 1'b1;
               cnt_val   = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (cnt_done) begin
               state_nxt = ST_STROBE;
               cnt_load  = 1'b1;
               cnt_val   = STROBE_LD;
            end
         end
         ST_STROBE: begin
            if (cnt_done) begin
               capture   = ~wr_q;
               state_nxt = ST_HOLD;
               cnt_load  = 1'b1;
               cnt_val   = HOLD_LD;
            end
         end
         ST_HOLD: begin
            if (cnt_done) begin
               ack_nxt = 1'b1;
               if (!wr_q && HAS_TURN) begin
                  state_nxt = ST_TURN;
                  cnt_load  = 1'b1;
                  cnt_val   = TURN_LD;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_TURN: begin
            if (cnt_done) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Pins are registered, so they are derived from the state being entered
   // and from the request fields as they will be latched on this edge.
   assign wr_sel     = accept ? req_write : wr_q;
   assign be_sel     = accept ? req_be : be_q;
   assign active_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) ||
                       (state_nxt == ST_HOLD);
   assign strobe_nxt = (state_nxt == ST_STROBE);

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         wr_q        <= 1'b0;
         be_q        <= '0;
         req_ready   <= 1'b1;
         ack         <= 1'b0;
         busy        <= 1'b0;
         rdata       <= '0;
         ebi_addr    <= '0;
         ebi_data_o  <= '0;
         cs_n        <= IDLE_CS_N;
         oe_n        <= IDLE_OE_N;
         we_n        <= IDLE_WE_N;
         rd_wr       <= IDLE_RD_WR;
         ebi_data_oe <= IDLE_DATA_OE;
      end else begin
         state <= state_nxt;
         if (accept) begin
            wr_q     <= req_write;
            be_q     <= req_be;
            ebi_addr <= req_addr;
            if (req_write) begin
               ebi_data_o <= req_wdata;
            end
         end
         if (capture) begin
            rdata <= ebi_data_i;
         end
         req_ready   <= (state_nxt == ST_IDLE);
         busy        <= (state_nxt != ST_IDLE);
         ack         <= ack_nxt;
         cs_n        <= active_nxt ? 1'b0 : IDLE_CS_N;
         oe_n        <= (strobe_nxt && !wr_sel) ? 1'b0 : IDLE_OE_N;
         we_n        <= (strobe_nxt && wr_sel) ? ~be_sel : IDLE_WE_N;
         rd_wr       <= active_nxt ? (wr_sel ? WR : RD) : IDLE_RD_WR;
         ebi_data_oe <= active_nxt && wr_sel;
      end
   end

endmodule

// File: doc/ebi_master.md
# ebi_master

Synchronous initiator for the PowerPC-style external bus interface (EBI): it converts a single-word request/acknowledge handshake into a chip-select/strobe bus cycle with programmable setup, strobe, hold and turnaround lengths. It drives the same pin set that the FPGA-side register/UART/NAND responder decodes: cs_n, oe_n, byte-lane we_n, rd_wr, 24-bit word address and a 32-bit data bus. It sits inside the second core's FPGA, or in a verification harness, as the bus master. Tristating of the data bus is done one level up from the split data_o/data_oe/data_i ports.

## Interface
- SETUP_CYC, 1: cycles with cs_n low and address valid before the strobe; legal range 1..15.
- STROBE_CYC, 3: cycles with oe_n or we_n asserted; legal range 1..15.
- HOLD_CYC, 1: cycles with cs_n low after the strobe deasserts; legal range 1..15.
- TURN_CYC, 1: idle cycles after a read before the next request is accepted; legal range 0..15.
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  24  word address driven onto ebi_addr (A31..A8)
- req_be  in  4  byte enables, bit i covers data[8i+7:8i]
- req_wdata  in  32  write data
- ack  out  1  one-cycle completion pulse
- rdata  out  32  read data, valid while ack=1 for a read; holds its value otherwise
- busy  out  1  high whenever state is not IDLE
- cs_n  out  1  chip select, active low
- oe_n  out  1  output enable, active low
- we_n  out  4  per-byte write strobes, active low
- rd_wr  out  1  1 = read, 0 = write
- ebi_addr  out  24  bus address
- ebi_data_o  out  32  bus write data
- ebi_data_oe  out  1  1 = master drives the data bus
- ebi_data_i  in  32  bus read data

## Operation
- States: IDLE, SETUP, STROBE, HOLD, TURN. Each state uses one 4-bit down-counter, loaded with (param − 1) on entry.
- IDLE: req_ready=1. On accept, latch write/addr/be/wdata and go to SETUP.
- SETUP: cs_n=0, ebi_addr=latched address, rd_wr=~write. For writes, ebi_data_oe=1. After SETUP_CYC cycles go to STROBE.
- STROBE, read: oe_n=0. ebi_data_i is registered into rdata on the clock edge that ends the last STROBE cycle.
- STROBE, write: we_n=~be. With be=0000 the bus cycle still runs and we_n stays 1111.
- HOLD: strobes are deasserted; cs_n, address, rd_wr and write data are held. After HOLD_CYC cycles, pulse ack for 1 cycle.
  - Read with TURN_CYC>0: go to TURN.
  - Otherwise: go to IDLE.
- TURN: all bus outputs are idle. After TURN_CYC cycles, go to IDLE.
- Idle bus values: cs_n=1, oe_n=1, we_n=1111, rd_wr=1, ebi_data_oe=0. ebi_addr and ebi_data_o hold their last values.
- ebi_data_oe is high only in SETUP, STROBE and HOLD of a write. This guarantees no contention with a responder that drives the bus while oe_n is low.
- A request presented while req_ready=0 is ignored. Holding it until accept is the requester's job.
- Reset, including in the middle of a cycle: on the next edge state=IDLE, all bus outputs go to idle values, no ack is issued, and the latched request is discarded.
- All outputs are registered.
  - Reset values: req_ready=1, ack=0, busy=0, rdata=0, ebi_addr=0, ebi_data_o=0, plus the idle bus values above.

## Timing
- Accept at edge T0 puts cs_n=0 from T0+1.
- The strobe asserts at T0+1+SETUP_CYC and lasts STROBE_CYC cycles.
- ack is high during cycle T0+1+SETUP_CYC+STROBE_CYC+HOLD_CYC.
  - With defaults this is T0+6.
- req_ready returns high together with ack for writes.
- For reads, req_ready returns TURN_CYC cycles after ack.
- Back-to-back writes: cs_n returns high for exactly one cycle (the IDLE/accept cycle) between cycles.
- Throughput with defaults: a write every 6 cycles; a read every 7 cycles.

## Structure
- A shared package ebi_pkg holds:
  - the state enum;
  - the idle-value constants;
  - the 4-bit counter width;
  - the RD=1/WR=0 encoding of rd_wr.
- Sub-module ebi_wait_cnt: loadable 4-bit down-counter with a done flag, used for all four phases.
- Parameter range checks are static elaboration assertions.

## Test plan
- Reset, then a single write of addr=0x000010, be=1111, wdata=0xDEADBEEF, defaults:
  - cs_n low for 5 cycles; we_n=0000 for exactly 3 cycles; ebi_data_oe=1 for 5 cycles;
  - ack at T0+6; req_ready high at T0+6.
- Read of addr=0x000004 with the bus model returning 0x12345678 while oe_n=0:
  - rdata=0x12345678 with ack at T0+6; ebi_data_oe never asserts;
  - req_ready is low until T0+7.
- Partial write with be=0101: we_n=1010 during STROBE; with be=0000, we_n stays 1111 and ack still fires.
- Back-to-back read then write with req_valid held high:
  - second accept occurs after the TURN cycle;
  - ebi_data_oe=0 for at least 1 cycle after oe_n rises.
- SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1, TURN_CYC=0, write: ack at T0+4; repeat with all parameters at 15 and check ack at T0+46.
- rst asserted during STROBE of a write:
  - next cycle cs_n=1, we_n=1111, ebi_data_oe=0, ack never pulses, req_ready=1;
  - the following request completes normally.
